// File: rtl/fsm_rd_arb_if.sv
// Handshake bundle between the round-robin read arbiter, its requesters and the read sequencer.
// The master side is the arbiter; the slave side is the requesters plus the sequencer.
interface fsm_rd_arb_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             err;
  logic             busy;
  logic             go;
  logic             ds;

  modport master (
    input  req,
    input  ds,
    output gnt,
    output done,
    output err,
    output busy,
    output go
  );

  modport slave (
    output req,
    output ds,
    input  gnt,
    input  done,
    input  err,
    input  busy,
    input  go
  );
endinterface

// File: rtl/fsm_rd_arb.sv
// Round-robin arbiter that shares one go/ds read sequencer among N_REQ requesters,
// with a watchdog that aborts a grant whose completion strobe never arrives.
module fsm_rd_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  fsm_rd_arb_if.master bus
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRelease} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              go_q, go_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [PtrW-1:0]   cand;
  logic [PtrW-1:0]   pick_idx;
  logic              pick_vld;

  // Search upward from the slot after the last winner, wrapping, so the last winner goes last.
  always_comb begin
    cand     = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      ptr_q   <= PtrW'(N_REQ - 1);
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    go_d    = 1'b0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StIssue;
          gnt_d   = N_REQ'(1) << pick_idx;
          win_d   = pick_idx;
          go_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion on the expiry edge still counts as a normal completion.
        if (bus.ds) begin
          state_d = StRelease;
          done_d  = gnt_q;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StRelease;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = win_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.gnt  = gnt_q;
    bus.done = done_q;
    bus.err  = err_q;
    bus.busy = busy_q;
    bus.go   = go_q;
  end

endmodule

// File: tb/tb_fsm_rd_arb.sv
// Self-checking bench for fsm_rd_arb: directed scenarios followed by randomized transactions,
// predicted by a transaction-level round-robin and completion-timing model.
module tb_fsm_rd_arb;

  localparam int N  = 4;
  localparam int TO = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  int   last_win;

  fsm_rd_arb_if #(.N_REQ(N)) bus ();

  fsm_rd_arb #(
    .N_REQ  (N),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Round-robin winner: first requester after the previous winner, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int i = 1; i <= N; i++) begin
      idx = (last + i) % N;
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_go"}, 32'(bus.go), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  // One transaction; d = WAIT edges without ds before ds arrives (d >= TO means never).
  task automatic run_txn(input logic [N-1:0] r, input int d, input bit drop, input bit ds_issue);
    logic [N-1:0] eg;
    int           w;
    int           e;
    logic         ee;
    w  = pick(r, last_win);
    eg = N'(1) << w;
    e  = (d < TO) ? d + 1 : TO;
    ee = (d >= TO);
    bus.req = r;
    bus.ds  = 1'b0;
    @(negedge clk);
    chk("grant", 32'(bus.gnt), 32'(eg));
    chk("go_pulse", 32'(bus.go), 1);
    chk("busy_on", 32'(bus.busy), 1);
    chk("no_done_issue", 32'(bus.done), 0);
    bus.ds = ds_issue;
    @(negedge clk);
    chk("go_low", 32'(bus.go), 0);
    chk("gnt_hold", 32'(bus.gnt), 32'(eg));
    if (drop) bus.req = r & ~eg;
    for (int j = 1; j <= e; j++) begin
      bus.ds = (j == d + 1);
      @(negedge clk);
      chk("gnt_wait", 32'(bus.gnt), 32'(eg));
      if (j < e) chk("no_early_done", 32'(bus.done), 0);
    end
    bus.ds = 1'b0;
    chk("done", 32'(bus.done), 32'(eg));
    chk("err", 32'(bus.err), 32'(ee));
    chk("busy_release", 32'(bus.busy), 1);
    @(negedge clk);
    chk_quiet("after_release");
    last_win = w;
  endtask

  initial begin
    int r;
    int d;
    checks  = 0;
    passed  = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.ds  = 1'b0;
    last_win = N - 1;
    @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("idle");

    run_txn(4'b0001, 3, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) run_txn(4'b1111, k, 1'b0, 1'b0);
    run_txn(4'b0101, 1, 1'b1, 1'b0);
    run_txn(4'b0101, 2, 1'b0, 1'b0);
    run_txn(4'b0101, 0, 1'b1, 1'b0);

    run_txn(4'b1111, TO + 10, 1'b0, 1'b0);
    run_txn(4'b1111, 2, 1'b0, 1'b0);

    bus.req = '0;
    bus.ds  = 1'b1;
    @(negedge clk);
    chk_quiet("ds_in_idle");
    bus.ds = 1'b0;
    run_txn(4'b0011, 4, 1'b0, 1'b1);
    run_txn(4'b1000, TO - 1, 1'b0, 1'b0);

    // Asynchronous reset while a grant to requester 2 is waiting.
    bus.req = 4'b0100;
    @(negedge clk);
    chk("pre_reset_gnt", 32'(bus.gnt), 32'h4);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_quiet("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = '0;
    last_win = N - 1;
    run_txn(4'b1111, 1, 1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        bus.ds  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_quiet("rand_idle");
      end
      r = $urandom_range(0, 9);
      d = (r < 8) ? r : ((r == 8) ? TO - 1 : TO + 5);
      run_txn(N'($urandom_range(1, 15)), d, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fsm_rd_arb.md
# fsm_rd_arb

Round-robin arbiter and sequencer that shares one read-sequencer FSM (`go`/`ds` handshake) among `N_REQ` requesters. It grants one requester at a time, pulses `go` to start the sequencer, and waits for the sequencer's `ds` completion strobe. It then returns a per-requester `done` pulse and rotates priority. A watchdog aborts the grant if `ds` never arrives.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort, at least 2.

- `clk`  input  1  single clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  N_REQ  level request per requester.
- `gnt`  output  N_REQ  one-hot grant, held for the whole transaction; registered.
- `done`  output  N_REQ  one-cycle completion pulse to the granted requester; registered.
- `err`  output  1  one-cycle pulse, coincident with `done`, when the transaction ended by timeout; registered.
- `busy`  output  1  high whenever state is not IDLE; registered.
- `go`  output  1  one-cycle start strobe to the read sequencer; registered.
- `ds`  input  1  completion strobe from the read sequencer.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE. State is encoded as a 2-bit enum. Any illegal state returns to IDLE.
- Reset values:
  - state = IDLE
  - `gnt` = 0, `done` = 0, `err` = 0, `busy` = 0, `go` = 0
  - priority pointer `ptr` = N_REQ-1, so requester 0 has highest priority first
  - watchdog count = 0
- IDLE:
  - If `req` is non-zero, select the winner: the first set bit searching upward from `(ptr+1) mod N_REQ`, wrapping around.
  - Next state ISSUE. Load `gnt` with the winner (one-hot). Set `go`=1 and `busy`=1.
  - If `req` is zero, remain in IDLE with all outputs 0.
- ISSUE: `go` returns to 0. Clear the watchdog count. Go to WAIT. `ds` is ignored in this state.
- WAIT:
  - If `ds`=1: go to RELEASE. Set `done` = `gnt` and `err`=0.
  - Otherwise, if watchdog count = TIMEOUT-1: go to RELEASE. Set `done` = `gnt` and `err`=1.
  - Otherwise, increment the watchdog count. The counter is `$clog2(TIMEOUT)` bits and saturates; it never wraps.
- RELEASE:
  - Clear `gnt`, `done`, `err`, and `busy`. Set `ptr` to the index of the winner. Go to IDLE.
  - `req` is not sampled in RELEASE.
- Requester rules:
  - Dropping `req` while granted does not shorten the transaction. `gnt` holds until RELEASE and `done` still pulses.
  - A requester that keeps `req` high after its `done` is eligible again, at lowest priority behind all the others.
- `ds` outside WAIT is ignored: no state change, no `done`.
- `gnt` is never multi-hot and never changes between ISSUE and RELEASE.
- Reset mid-transaction: all outputs clear asynchronously and `ptr` returns to N_REQ-1. The sequencer is not reset by this block; system reset covers it.

## Timing
- `req` sampled high at edge k in IDLE, giving after edge k:
  - `gnt` valid
  - `go`=1 for exactly one cycle
  - `busy`=1
- Edge k+1: ISSUE to WAIT.
- `ds` high at WAIT edge m: `done` and `err` are valid for one cycle after edge m, and `gnt` is still asserted during that cycle.
- Edge m+1: `gnt`=0, IDLE.
- Edge m+2: earliest next arbitration.
- Minimum throughput: one transaction per 4 cycles plus the sequencer latency.
- Timeout: with no `ds`, `done`/`err` assert after exactly TIMEOUT WAIT edges.
- Same-cycle events at a WAIT edge: `ds`=1 together with watchdog expiry resolves as normal completion (`err`=0).

## Test plan
- Reset, then `req`=0001 with `ds` 3 cycles into WAIT:
  - `gnt`=0001 and `go` pulse after the first edge
  - `done`=0001 one cycle, `err`=0
  - `busy` falls one cycle later
- `req`=1111 held, every transaction answered with `ds`: grants appear in order 0001, 0010, 0100, 1000, 0001. `gnt` is never multi-hot.
- `req`=0101 held:
  - grants alternate 0001, 0100
  - requester 0 dropping `req` mid-WAIT still receives `done`=0001
- No `ds`, TIMEOUT=64:
  - `done`=0001 and `err`=1 exactly 64 WAIT cycles after ISSUE
  - next grant goes to the next requester
- `ds` pulsed while in IDLE and while in ISSUE: no `done`, and the state sequence is unchanged. `ds` at the same edge as expiry gives `err`=0.
- `rst_n` asserted low during WAIT with `gnt`=0100:
  - all outputs 0 immediately
  - after release, `req`=1111 grants 0001 first
